// File: rtl/control_unit_fsm.sv
// Multi-cycle CPU control unit: IF/ID/EXE/MEM/WB sequencing plus
// opcode decode for PC, IR, register file, ALU, data memory and DB path.
module control_unit_fsm (
    input  logic       CLK,
    input  logic       Reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       sign,
    output logic [2:0] state,
    output logic       PCWre,
    output logic       IRWre,
    output logic       RegWre,
    output logic       mRD,
    output logic       mWR,
    output logic [1:0] PCSrc,
    output logic       ALUSrcA,
    output logic       ALUSrcB,
    output logic       ExtSel,
    output logic [2:0] ALUOp,
    output logic [1:0] RegDst,
    output logic       WrRegDSrc,
    output logic       DBDataSrc
);

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_OR   = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_ORI  = 6'b010010;
    localparam logic [5:0] OP_SLL  = 6'b011000;
    localparam logic [5:0] OP_SLT  = 6'b100110;
    localparam logic [5:0] OP_SW   = 6'b110000;
    localparam logic [5:0] OP_LW   = 6'b110001;
    localparam logic [5:0] OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_BNE  = 6'b110101;
    localparam logic [5:0] OP_BLTZ = 6'b110110;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_JR   = 6'b111001;
    localparam logic [5:0] OP_JAL  = 6'b111010;
    localparam logic [5:0] OP_HALT = 6'b111111;

    typedef enum logic [2:0] {
        S_IF     = 3'b000,
        S_ID     = 3'b001,
        S_EXE_M  = 3'b010,
        S_MEM    = 3'b011,
        S_WB_L   = 3'b100,
        S_EXE_BR = 3'b101,
        S_EXE_R  = 3'b110,
        S_WB_R   = 3'b111
    } state_e;

    state_e state_q, state_d;

    logic is_alu, is_sw, is_lw, is_beq, is_bne, is_bltz;
    logic is_j, is_jr, is_jal, is_halt, is_br, is_nop, taken;

    always_comb begin
        is_alu  = (opcode == OP_ADD) || (opcode == OP_SUB)
               || (opcode == OP_ADDI) || (opcode == OP_OR)
               || (opcode == OP_AND) || (opcode == OP_ORI)
               || (opcode == OP_SLL) || (opcode == OP_SLT);
        is_sw   = (opcode == OP_SW);
        is_lw   = (opcode == OP_LW);
        is_beq  = (opcode == OP_BEQ);
        is_bne  = (opcode == OP_BNE);
        is_bltz = (opcode == OP_BLTZ);
        is_j    = (opcode == OP_J);
        is_jr   = (opcode == OP_JR);
        is_jal  = (opcode == OP_JAL);
        is_halt = (opcode == OP_HALT);
        is_br   = is_beq || is_bne || is_bltz;
        is_nop  = !(is_alu || is_sw || is_lw || is_br
                 || is_j || is_jr || is_jal || is_halt);
        taken   = (is_beq && zero) || (is_bne && !zero)
               || (is_bltz && sign);
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) state_q <= S_IF;
        else        state_q <= state_d;
    end

    assign state = state_q;

    always_comb begin
        state_d = state_q;
        PCWre   = 1'b0;
        IRWre   = 1'b0;
        RegWre  = 1'b0;
        mRD     = 1'b0;
        mWR     = 1'b0;
        PCSrc   = 2'b00;
        unique case (state_q)
            S_IF: begin
                IRWre   = 1'b1;
                state_d = S_ID;
            end
            S_ID: begin
                if (is_halt) begin
                    state_d = S_ID;
                end else if (is_j || is_jr || is_jal || is_nop) begin
                    PCWre   = 1'b1;
                    RegWre  = is_jal;
                    PCSrc   = is_jr ? 2'b10 :
                              (is_j || is_jal) ? 2'b11 : 2'b00;
                    state_d = S_IF;
                end else if (is_br) begin
                    state_d = S_EXE_BR;
                end else if (is_lw || is_sw) begin
                    state_d = S_EXE_M;
                end else begin
                    state_d = S_EXE_R;
                end
            end
            S_EXE_R:  state_d = S_WB_R;
            S_EXE_BR: begin
                PCWre   = 1'b1;
                PCSrc   = taken ? 2'b01 : 2'b00;
                state_d = S_IF;
            end
            S_EXE_M:  state_d = S_MEM;
            S_MEM: begin
                if (is_lw) begin
                    mRD     = 1'b1;
                    state_d = S_WB_L;
                end else begin
                    mWR     = is_sw;
                    PCWre   = 1'b1;
                    state_d = S_IF;
                end
            end
            S_WB_R, S_WB_L: begin
                PCWre   = 1'b1;
                RegWre  = 1'b1;
                state_d = S_IF;
            end
        endcase
        // reset must kill every write strobe even before the state flop settles
        if (!Reset) begin
            PCWre  = 1'b0;
            IRWre  = 1'b0;
            RegWre = 1'b0;
            mRD    = 1'b0;
            mWR    = 1'b0;
            PCSrc  = 2'b00;
        end
    end

    always_comb begin
        ALUSrcA   = (opcode == OP_SLL);
        ALUSrcB   = (opcode == OP_ADDI) || (opcode == OP_ORI)
                 || is_lw || is_sw;
        ExtSel    = (opcode != OP_ORI);
        WrRegDSrc = !is_jal;
        DBDataSrc = is_lw;
        ALUOp     = 3'b000;
        RegDst    = 2'b10;
        unique case (1'b1)
            (opcode == OP_SUB), is_br:        ALUOp = 3'b001;
            (opcode == OP_SLL):               ALUOp = 3'b010;
            (opcode == OP_OR), (opcode == OP_ORI): ALUOp = 3'b011;
            (opcode == OP_AND):               ALUOp = 3'b100;
            (opcode == OP_SLT):               ALUOp = 3'b101;
            default:                          ALUOp = 3'b000;
        endcase
        if (is_jal)
            RegDst = 2'b00;
        else if ((opcode == OP_ADDI) || (opcode == OP_ORI) || is_lw)
            RegDst = 2'b01;
    end

endmodule

// File: tb/tb_control_unit_fsm.sv
// Random and directed instruction streams checked against a per-instruction
// cycle-schedule model of the control unit.
module tb_control_unit_fsm;

    logic       CLK, Reset, zero, sign;
    logic [5:0] opcode;
    logic [2:0] state, ALUOp;
    logic       PCWre, IRWre, RegWre, mRD, mWR;
    logic [1:0] PCSrc, RegDst;
    logic       ALUSrcA, ALUSrcB, ExtSel, WrRegDSrc, DBDataSrc;

    int nchk = 0;
    int nerr = 0;

    control_unit_fsm dut (
        .CLK(CLK), .Reset(Reset), .opcode(opcode), .zero(zero),
        .sign(sign), .state(state), .PCWre(PCWre), .IRWre(IRWre),
        .RegWre(RegWre), .mRD(mRD), .mWR(mWR), .PCSrc(PCSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ExtSel(ExtSel),
        .ALUOp(ALUOp), .RegDst(RegDst), .WrRegDSrc(WrRegDSrc),
        .DBDataSrc(DBDataSrc)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    localparam int K_ALU = 0, K_LW = 1, K_SW = 2, K_BR = 3, K_J = 4;
    localparam int K_JR = 5, K_JAL = 6, K_HALT = 7, K_NOP = 8;

    logic [5:0] valid_ops [17] = '{
        6'o00, 6'o01, 6'o02, 6'o20, 6'o21, 6'o22, 6'o30, 6'o46,
        6'o60, 6'o61, 6'o64, 6'o65, 6'o66, 6'o70, 6'o71, 6'o72, 6'o77
    };

    function automatic int kind_of(input logic [5:0] op);
        case (op)
            6'o00, 6'o01, 6'o02, 6'o20,
            6'o21, 6'o22, 6'o30, 6'o46: return K_ALU;
            6'o61: return K_LW;
            6'o60: return K_SW;
            6'o64, 6'o65, 6'o66: return K_BR;
            6'o70: return K_J;
            6'o71: return K_JR;
            6'o72: return K_JAL;
            6'o77: return K_HALT;
            default: return K_NOP;
        endcase
    endfunction

    // {ALUSrcA, ALUSrcB, ExtSel, ALUOp, RegDst, WrRegDSrc, DBDataSrc}
    function automatic logic [10:0] dec_of(input logic [5:0] op);
        logic a = 0, b = 0, e = 1, w = 1, d = 0;
        logic [2:0] alu = 3'd0;
        logic [1:0] rd = 2'd2;
        case (op)
            6'o01: alu = 3'd1;
            6'o02: begin b = 1; rd = 2'd1; end
            6'o20: alu = 3'd3;
            6'o21: alu = 3'd4;
            6'o22: begin b = 1; e = 0; alu = 3'd3; rd = 2'd1; end
            6'o30: begin a = 1; alu = 3'd2; end
            6'o46: alu = 3'd5;
            6'o60: b = 1;
            6'o61: begin b = 1; rd = 2'd1; d = 1; end
            6'o64, 6'o65, 6'o66: alu = 3'd1;
            6'o72: begin rd = 2'd0; w = 0; end
            default: ;
        endcase
        return {a, b, e, alu, rd, w, d};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_dec();
        chk("decode", {5'd0, ALUSrcA, ALUSrcB, ExtSel, ALUOp, RegDst,
                       WrRegDSrc, DBDataSrc}, {5'd0, dec_of(opcode)});
    endtask

    // Drive one instruction; check every cycle against its schedule.
    task automatic run_instr(input logic [5:0] op, input bit rnd,
                             input int stop);
        int k, n, last;
        logic [2:0] seq[$];
        logic [1:0] epc;
        bit tk;
        k = kind_of(op);
        case (k)
            K_ALU:   seq = '{3'd0, 3'd1, 3'd6, 3'd7};
            K_LW:    seq = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
            K_SW:    seq = '{3'd0, 3'd1, 3'd2, 3'd3};
            K_BR:    seq = '{3'd0, 3'd1, 3'd5};
            default: seq = '{3'd0, 3'd1};
        endcase
        last = seq.size() - 1;
        n = (stop >= 0 && stop <= last) ? stop : last + 1;
        opcode = op;
        for (int s = 0; s < n; s++) begin
            if (rnd) begin
                zero = 1'($urandom_range(1));
                sign = 1'($urandom_range(1));
            end
            #1;
            tk = (op == 6'o64 && zero) || (op == 6'o65 && !zero)
              || (op == 6'o66 && sign);
            epc = 2'd0;
            if (s == last) begin
                if (k == K_J || k == K_JAL) epc = 2'd3;
                else if (k == K_JR)         epc = 2'd2;
                else if (k == K_BR && tk)   epc = 2'd1;
            end
            chk("state", 16'(state), 16'(seq[s]));
            chk("IRWre", 16'(IRWre), 16'(s == 0));
            chk("PCWre", 16'(PCWre), 16'(s == last));
            chk("RegWre", 16'(RegWre), 16'((s == last &&
                (k == K_ALU || k == K_LW)) || (s == 1 && k == K_JAL)));
            chk("mRD", 16'(mRD), 16'(k == K_LW && s == 3));
            chk("mWR", 16'(mWR), 16'(k == K_SW && s == 3));
            chk("PCSrc", 16'(PCSrc), 16'(epc));
            chk_dec();
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic do_halt(input int cycles);
        opcode = 6'o77;
        #1;
        chk("halt_if", 16'(state), 16'd0);
        chk("halt_ir", 16'(IRWre), 16'd1);
        @(posedge CLK);
        #1;
        for (int i = 0; i < cycles; i++) begin
            zero = 1'($urandom_range(1));
            sign = 1'($urandom_range(1));
            #1;
            chk("halt_state", 16'(state), 16'd1);
            chk("halt_en", 16'({PCWre, IRWre, RegWre, mRD, mWR, PCSrc}),
                16'd0);
            chk_dec();
            @(posedge CLK);
            #1;
        end
        Reset = 1'b0;
        #1;
        chk("halt_rst", 16'(state), 16'd0);
        Reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] op;
        Reset = 1'b0;
        opcode = 6'o00;
        zero = 1'b0;
        sign = 1'b0;
        #2;
        chk("rst_state", 16'(state), 16'd0);
        chk("rst_en", 16'({PCWre, IRWre, RegWre, mRD, mWR}), 16'd0);
        #10;
        Reset = 1'b1;

        // reset asserted mid-sEXE_R, then the add restarts from IF
        run_instr(6'o00, 1, 2);
        chk("pre_rst", 16'(state), 16'd6);
        Reset = 1'b0;
        #1;
        chk("mid_rst_state", 16'(state), 16'd0);
        chk("mid_rst_en", 16'({PCWre, IRWre, RegWre, mRD, mWR}), 16'd0);
        Reset = 1'b1;
        run_instr(6'o00, 1, -1);

        run_instr(6'o61, 1, -1);
        run_instr(6'o60, 1, -1);
        zero = 1'b1; run_instr(6'o64, 0, -1);
        zero = 1'b0; run_instr(6'o64, 0, -1);
        sign = 1'b1; run_instr(6'o66, 0, -1);
        zero = 1'b0; run_instr(6'o65, 0, -1);
        run_instr(6'o72, 1, -1);
        run_instr(6'o71, 1, -1);
        run_instr(6'o70, 1, -1);
        run_instr(6'o52, 1, -1);
        do_halt(20);

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(3) == 0)
                op = 6'($urandom_range(63));
            else
                op = valid_ops[$urandom_range(16)];
            if (op == 6'o77) do_halt(3);
            else run_instr(op, 1, -1);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
